// File: rtl/psc_code_packer.sv
// Packs variable-width codes LSB-first into fixed WORD_W-bit words; a flush
// request drains any partial word zero-padded and tagged with its bit count.
module psc_code_packer #(
    parameter int CODE_W = 9,
    parameter int WORD_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reproducible_button_n,
    input  logic [CODE_W-1:0]         in_code,
    input  logic [3:0]                in_width,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush_req,
    output logic [WORD_W-1:0]         out_word,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [$clog2(WORD_W):0]   out_bits,
    output logic                      err_width,
    output logic [CNT_W-1:0]          words_out
);

    localparam int AW = WORD_W + CODE_W - 1;
    localparam int CW = $clog2(WORD_W + CODE_W);
    localparam int BW = $clog2(WORD_W) + 1;

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t              state;
    logic [AW-1:0]       acc;
    logic [CW-1:0]       cnt;

    logic                width_bad;
    logic [3:0]          eff_width;
    logic [CODE_W-1:0]   code_masked;
    logic                full;
    logic                has_bits;
    logic                in_fire;
    logic                out_fire;

    always_comb begin
        width_bad = in_width > 4'(CODE_W);
        eff_width = width_bad ? '0 : in_width;
        code_masked = '0;
        for (int unsigned i = 0; i < CODE_W; i++) begin
            code_masked[i] = in_code[i] && (i < 32'(eff_width));
        end
    end

    // All handshake outputs decode from registered state only.
    assign full      = cnt >= CW'(WORD_W);
    assign has_bits  = cnt != '0;
    assign out_valid = full || (state == DRAIN && has_bits);
    assign out_last  = (state == DRAIN) && has_bits && !full;
    assign out_bits  = full ? BW'(WORD_W) : (out_last ? BW'(cnt) : '0);
    assign out_word  = acc[WORD_W-1:0];
    assign in_ready  = (state == ACCUM) && !full;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge reproducible_button_n) begin
        if (!reproducible_button_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            err_width <= 1'b0;
            words_out <= '0;
        end else begin
            // in_fire needs cnt<WORD_W in ACCUM, out_fire needs cnt>=WORD_W or DRAIN,
            // so the two never coincide.
            if (in_fire) begin
                acc <= acc | (AW'(code_masked) << cnt);
                cnt <= cnt + CW'(eff_width);
                if (width_bad) err_width <= 1'b1;
            end else if (out_fire) begin
                words_out <= words_out + CNT_W'(1);
                if (full) begin
                    acc <= acc >> WORD_W;
                    cnt <= cnt - CW'(WORD_W);
                end else begin
                    acc <= '0;
                    cnt <= '0;
                end
            end

            case (state)
                ACCUM: if (flush_req) state <= DRAIN;
                DRAIN: if (!has_bits || (out_fire && !full)) state <= ACCUM;
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_psc_code_packer.sv
// Directed table-driven bench for psc_code_packer plus hand-written
// sequences for backpressure and asynchronous reset during a drain.
module tb_psc_code_packer;

    logic        clk;
    logic        rst_n;
    logic [8:0]  in_code;
    logic [3:0]  in_width;
    logic        in_valid;
    logic        in_ready;
    logic        flush_req;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [4:0]  out_bits;
    logic        err_width;
    logic [15:0] words_out;

    int n_vec  = 0;
    int n_miss = 0;

    psc_code_packer #(.CODE_W(9), .WORD_W(16), .CNT_W(16)) dut (
        .clk                   (clk),
        .reproducible_button_n (rst_n),
        .in_code               (in_code),
        .in_width              (in_width),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .flush_req             (flush_req),
        .out_word              (out_word),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_last              (out_last),
        .out_bits              (out_bits),
        .err_width             (err_width),
        .words_out             (words_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  code;
        logic [3:0]  width;
        logic        valid;
        logic        flush;
        logic        ordy;
        logic        e_ov;
        logic        e_last;
        logic        e_ir;
        logic        e_err;
        logic [15:0] e_word;
        logic [4:0]  e_bits;
        logic [15:0] e_words;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ov, input logic last, input logic ir,
                            input logic err, input logic [15:0] word, input logic [4:0] bits,
                            input logic [15:0] words);
        n_vec++;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".out_last"},  32'(out_last),  32'(last));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".err_width"}, 32'(err_width), 32'(err));
        chk({tag, ".out_word"},  32'(out_word),  32'(word));
        chk({tag, ".out_bits"},  32'(out_bits),  32'(bits));
        chk({tag, ".words_out"}, 32'(words_out), 32'(words));
    endtask

    task automatic drive(input logic [8:0] code, input logic [3:0] width, input logic valid,
                         input logic flush, input logic ordy);
        in_code   = code;
        in_width  = width;
        in_valid  = valid;
        flush_req = flush;
        out_ready = ordy;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flush_req = 1'b0;
    endtask

    initial begin
        // code width valid flush ordy | ov last ir err word bits words (post-edge)
        tbl[0]  = '{9'h000, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0,  16'd0};
        tbl[1]  = '{9'h0A5, 4'd8,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00A5, 5'd0,  16'd0};
        tbl[2]  = '{9'h03C, 4'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3CA5, 5'd16, 16'd0};
        tbl[3]  = '{9'h000, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0,  16'd1};
        tbl[4]  = '{9'h1FF, 4'd9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h01FF, 5'd0,  16'd1};
        tbl[5]  = '{9'h1FF, 4'd9,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 5'd16, 16'd1};
        tbl[6]  = '{9'h000, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 5'd2,  16'd2};
        tbl[7]  = '{9'h000, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0,  16'd3};
        tbl[8]  = '{9'h015, 4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0015, 5'd0,  16'd3};
        tbl[9]  = '{9'h000, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0015, 5'd5,  16'd3};
        tbl[10] = '{9'h000, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0015, 5'd5,  16'd3};
        tbl[11] = '{9'h000, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0,  16'd4};
        tbl[12] = '{9'h1FA, 4'd3,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 5'd3,  16'd4};
        tbl[13] = '{9'h000, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0,  16'd5};
        tbl[14] = '{9'h1FF, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0,  16'd5};
        tbl[15] = '{9'h1FF, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 5'd0,  16'd5};
        tbl[16] = '{9'h007, 4'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0007, 5'd0,  16'd5};

        rst_n = 1'b0; in_code = '0; in_width = '0; in_valid = 1'b0;
        flush_req = 1'b0; out_ready = 1'b0;
        #3;
        chk_outs("reset", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 16'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].code, tbl[i].width, tbl[i].valid, tbl[i].flush, tbl[i].ordy);
            chk_outs($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_last, tbl[i].e_ir,
                     tbl[i].e_err, tbl[i].e_word, tbl[i].e_bits, tbl[i].e_words);
        end

        // Reset while draining a 7-bit partial word: acc=0x7F after appending 0xF at bit 3.
        drive(9'h00F, 4'd4, 1'b1, 1'b0, 1'b0);
        chk_outs("pre_drain", 1'b0, 1'b0, 1'b1, 1'b1, 16'h007F, 5'd0, 16'd5);
        drive(9'h000, 4'd0, 1'b0, 1'b1, 1'b0);
        chk_outs("drain7", 1'b1, 1'b1, 1'b0, 1'b1, 16'h007F, 5'd7, 16'd5);
        #2 rst_n = 1'b0;
        #1 chk_outs("async_rst", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 16'd0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(9'h000, 4'd0, 1'b0, 1'b0, 1'b1);
            chk_outs($sformatf("post_rst%0d", k), 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 16'd0);
        end

        // Backpressure: full word held stable for 10 cycles, then exactly one transfer.
        drive(9'h011, 4'd8, 1'b1, 1'b0, 1'b0);
        drive(9'h022, 4'd8, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk_outs($sformatf("stall%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 16'h2211, 5'd16, 16'd0);
            drive(9'h1FF, 4'd9, 1'b1, 1'b0, 1'b0);
        end
        chk_outs("stall_end", 1'b1, 1'b0, 1'b0, 1'b0, 16'h2211, 5'd16, 16'd0);
        drive(9'h000, 4'd0, 1'b0, 1'b0, 1'b1);
        chk_outs("release", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 16'd1);
        drive(9'h000, 4'd0, 1'b0, 1'b0, 1'b1);
        chk_outs("release_idle", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
